// File: rtl/execute_stage_pkg.sv
// Shared EX-stage types: ALU op codes, forwarding selects
// and branch funct3 codes.
package riscv_ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLT   = 4'b0101,
    ALU_SLTU  = 4'b0110,
    ALU_SLL   = 4'b0111,
    ALU_SRL   = 4'b1000,
    ALU_SRA   = 4'b1001,
    ALU_PASSB = 4'b1010,
    ALU_ADDPC = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage,
// bundled so the pipeline top wires one port.
interface execute_stage_if #(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_PC_WIDTH   = 11
);
  logic                    i_regwrite_e;
  logic                    i_memwrite_e;
  logic                    i_branch_e;
  logic                    i_jump_e;
  logic                    i_jalr_e;
  logic [1:0]              i_resultsrc_e;
  logic [3:0]              i_alucontrol_e;
  logic                    i_alusrc_e;
  logic [2:0]              i_funct3_e;
  logic [P_DATA_WIDTH-1:0] i_rd1_e;
  logic [P_DATA_WIDTH-1:0] i_rd2_e;
  logic [P_DATA_WIDTH-1:0] i_imm_e;
  logic [P_PC_WIDTH-1:0]   i_pc_e;
  logic [P_PC_WIDTH-1:0]   i_pc4_e;
  logic [4:0]              i_rd_addr_e;
  logic [1:0]              i_forward_a_e;
  logic [1:0]              i_forward_b_e;
  logic [P_DATA_WIDTH-1:0] i_result_w;
  logic                    i_stall_m;
  logic                    i_flush_m;

  logic                    o_pcsrc_e;
  logic [P_PC_WIDTH-1:0]   o_pc_target_e;
  logic                    o_regwrite_m;
  logic                    o_memwrite_m;
  logic [1:0]              o_resultsrc_m;
  logic [P_DATA_WIDTH-1:0] o_alu_result_m;
  logic [P_DATA_WIDTH-1:0] o_write_data_m;
  logic [4:0]              o_rd_addr_m;
  logic [P_PC_WIDTH-1:0]   o_pc4_m;
  logic [2:0]              o_storetype_m;

  modport master (
    output i_regwrite_e, i_memwrite_e, i_branch_e,
    output i_jump_e, i_jalr_e, i_resultsrc_e,
    output i_alucontrol_e, i_alusrc_e, i_funct3_e,
    output i_rd1_e, i_rd2_e, i_imm_e, i_pc_e, i_pc4_e,
    output i_rd_addr_e, i_forward_a_e, i_forward_b_e,
    output i_result_w, i_stall_m, i_flush_m,
    input  o_pcsrc_e, o_pc_target_e, o_regwrite_m,
    input  o_memwrite_m, o_resultsrc_m, o_alu_result_m,
    input  o_write_data_m, o_rd_addr_m, o_pc4_m,
    input  o_storetype_m
  );

  modport slave (
    input  i_regwrite_e, i_memwrite_e, i_branch_e,
    input  i_jump_e, i_jalr_e, i_resultsrc_e,
    input  i_alucontrol_e, i_alusrc_e, i_funct3_e,
    input  i_rd1_e, i_rd2_e, i_imm_e, i_pc_e, i_pc4_e,
    input  i_rd_addr_e, i_forward_a_e, i_forward_b_e,
    input  i_result_w, i_stall_m, i_flush_m,
    output o_pcsrc_e, o_pc_target_e, o_regwrite_m,
    output o_memwrite_m, o_resultsrc_m, o_alu_result_m,
    output o_write_data_m, o_rd_addr_m, o_pc4_m,
    output o_storetype_m
  );
endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU; ADDPC adds the zero-extended
// instruction PC for AUIPC.
module alu
  import riscv_ex_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_PC_WIDTH   = 11
) (
  input  logic [P_DATA_WIDTH-1:0] src_a,
  input  logic [P_DATA_WIDTH-1:0] src_b,
  input  logic [P_PC_WIDTH-1:0]   pc,
  input  logic [3:0]              op,
  output logic [P_DATA_WIDTH-1:0] result
);

  logic [4:0]              shamt;
  logic [P_DATA_WIDTH-1:0] pc_ext;

  assign shamt  = src_b[4:0];
  assign pc_ext = {{(P_DATA_WIDTH-P_PC_WIDTH){1'b0}}, pc};

  always_comb begin
    result = '0;
    case (alu_op_e'(op))
      ALU_ADD:   result = src_a + src_b;
      ALU_SUB:   result = src_a - src_b;
      ALU_AND:   result = src_a & src_b;
      ALU_OR:    result = src_a | src_b;
      ALU_XOR:   result = src_a ^ src_b;
      ALU_SLT:   result = P_DATA_WIDTH'(
                   $signed(src_a) < $signed(src_b));
      ALU_SLTU:  result = P_DATA_WIDTH'(src_a < src_b);
      ALU_SLL:   result = src_a << shamt;
      ALU_SRL:   result = src_a >> shamt;
      ALU_SRA:   result = $signed(src_a) >>> shamt;
      ALU_PASSB: result = src_b;
      ALU_ADDPC: result = pc_ext + src_b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch/jump resolve
// and the EX/MEM pipeline register.
module execute_stage
  import riscv_ex_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_PC_WIDTH   = 11
) (
  input logic          i_clk,
  input logic          i_rst_n,
  execute_stage_if.slave bus
);

  logic [P_DATA_WIDTH-1:0] fwd_a;
  logic [P_DATA_WIDTH-1:0] fwd_b;
  logic [P_DATA_WIDTH-1:0] src_b;
  logic [P_DATA_WIDTH-1:0] alu_res;
  logic [P_PC_WIDTH-1:0]   jalr_sum;
  logic                    cond;

  always_comb begin
    fwd_a = bus.i_rd1_e;
    case (fwd_sel_e'(bus.i_forward_a_e))
      FWD_WB:  fwd_a = bus.i_result_w;
      FWD_MEM: fwd_a = bus.o_alu_result_m;
      default: fwd_a = bus.i_rd1_e;
    endcase
  end

  always_comb begin
    fwd_b = bus.i_rd2_e;
    case (fwd_sel_e'(bus.i_forward_b_e))
      FWD_WB:  fwd_b = bus.i_result_w;
      FWD_MEM: fwd_b = bus.o_alu_result_m;
      default: fwd_b = bus.i_rd2_e;
    endcase
  end

  assign src_b = bus.i_alusrc_e ? bus.i_imm_e : fwd_b;

  alu #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_PC_WIDTH   (P_PC_WIDTH)
  ) u_alu (
    .src_a  (fwd_a),
    .src_b  (src_b),
    .pc     (bus.i_pc_e),
    .op     (bus.i_alucontrol_e),
    .result (alu_res)
  );

  // Compare always uses forwarded B, never the immediate
  always_comb begin
    cond = 1'b0;
    case (bus.i_funct3_e)
      F3_BEQ:  cond = fwd_a == fwd_b;
      F3_BNE:  cond = fwd_a != fwd_b;
      F3_BLT:  cond = $signed(fwd_a) < $signed(fwd_b);
      F3_BGE:  cond = $signed(fwd_a) >= $signed(fwd_b);
      F3_BLTU: cond = fwd_a < fwd_b;
      F3_BGEU: cond = fwd_a >= fwd_b;
      default: cond = 1'b0;
    endcase
  end

  assign bus.o_pcsrc_e =
    (bus.i_branch_e & cond) | bus.i_jump_e;

  // Low bits of the sum suffice: target is truncated anyway
  assign jalr_sum =
    fwd_a[P_PC_WIDTH-1:0] + bus.i_imm_e[P_PC_WIDTH-1:0];

  assign bus.o_pc_target_e = bus.i_jalr_e
    ? {jalr_sum[P_PC_WIDTH-1:1], 1'b0}
    : bus.i_pc_e + bus.i_imm_e[P_PC_WIDTH-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n || bus.i_flush_m) begin
      bus.o_regwrite_m   <= 1'b0;
      bus.o_memwrite_m   <= 1'b0;
      bus.o_resultsrc_m  <= '0;
      bus.o_alu_result_m <= '0;
      bus.o_write_data_m <= '0;
      bus.o_rd_addr_m    <= '0;
      bus.o_pc4_m        <= '0;
      bus.o_storetype_m  <= '0;
    end else if (!bus.i_stall_m) begin
      bus.o_regwrite_m   <= bus.i_regwrite_e;
      bus.o_memwrite_m   <= bus.i_memwrite_e;
      bus.o_resultsrc_m  <= bus.i_resultsrc_e;
      bus.o_alu_result_m <= alu_res;
      bus.o_write_data_m <= fwd_b;
      bus.o_rd_addr_m    <= bus.i_rd_addr_e;
      bus.o_pc4_m        <= bus.i_pc4_e;
      bus.o_storetype_m  <= bus.i_funct3_e;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Random + directed bench for execute_stage against an
// arithmetic reference model of the EX stage.
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  execute_stage_if #(.P_DATA_WIDTH(32), .P_PC_WIDTH(11)) bus();

  execute_stage #(.P_DATA_WIDTH(32), .P_PC_WIDTH(11)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic        m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_rd;
  logic [10:0] m_pc4;
  logic [2:0]  m_st;

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(
    int op, logic [31:0] a, logic [31:0] b, logic [10:0] pc);
    longint ua = a;
    longint ub = b;
    longint sa = $signed(a);
    longint sb = $signed(b);
    int sh = b % 32;
    case (op)
      0:  return 32'(ua + ub);
      1:  return 32'(ua - ub);
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return (sa < sb) ? 32'd1 : 32'd0;
      6:  return (ua < ub) ? 32'd1 : 32'd0;
      7:  return 32'(ua * (longint'(1) << sh));
      8:  return 32'(ua / (longint'(1) << sh));
      9:  return 32'(sa >>> sh);
      10: return b;
      11: return 32'(longint'(pc) + ub);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic br_ref(
    logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] fwd_ref(
    logic [1:0] sel, logic [31:0] rf);
    if (sel == 2'd1) return bus.i_result_w;
    if (sel == 2'd2) return m_alu;
    return rf;
  endfunction

  task automatic model_zero();
    m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0;
    m_wd = 0; m_rd = 0; m_pc4 = 0; m_st = 0;
  endtask

  task automatic check_regs(string tag);
    check({tag, ".regwrite"}, 32'(bus.o_regwrite_m), 32'(m_rw));
    check({tag, ".memwrite"}, 32'(bus.o_memwrite_m), 32'(m_mw));
    check({tag, ".resultsrc"}, 32'(bus.o_resultsrc_m), 32'(m_rs));
    check({tag, ".alu"}, bus.o_alu_result_m, m_alu);
    check({tag, ".wdata"}, bus.o_write_data_m, m_wd);
    check({tag, ".rd"}, 32'(bus.o_rd_addr_m), 32'(m_rd));
    check({tag, ".pc4"}, 32'(bus.o_pc4_m), 32'(m_pc4));
    check({tag, ".storetype"}, 32'(bus.o_storetype_m), 32'(m_st));
  endtask

  task automatic check_comb(string tag);
    logic [31:0] a, b;
    logic        taken;
    logic [10:0] tgt;
    a = fwd_ref(bus.i_forward_a_e, bus.i_rd1_e);
    b = fwd_ref(bus.i_forward_b_e, bus.i_rd2_e);
    taken = (bus.i_branch_e && br_ref(bus.i_funct3_e, a, b))
            || bus.i_jump_e;
    if (bus.i_jalr_e)
      tgt = 11'((longint'(a) + longint'(bus.i_imm_e)) / 2 * 2);
    else
      tgt = 11'(int'(bus.i_pc_e) + int'(bus.i_imm_e % 2048));
    check({tag, ".pcsrc"}, 32'(bus.o_pcsrc_e), 32'(taken));
    check({tag, ".target"}, 32'(bus.o_pc_target_e), 32'(tgt));
  endtask

  // Inputs must already be applied; ends 1 time unit past
  // the clock edge with the registered outputs checked.
  task automatic step(string tag);
    logic [31:0] a, b, sb, res;
    #1;
    check_comb(tag);
    a   = fwd_ref(bus.i_forward_a_e, bus.i_rd1_e);
    b   = fwd_ref(bus.i_forward_b_e, bus.i_rd2_e);
    sb  = bus.i_alusrc_e ? bus.i_imm_e : b;
    res = alu_ref(int'(bus.i_alucontrol_e), a, sb, bus.i_pc_e);
    @(posedge clk);
    if (!rst_n || bus.i_flush_m) model_zero();
    else if (!bus.i_stall_m) begin
      m_rw = bus.i_regwrite_e; m_mw = bus.i_memwrite_e;
      m_rs = bus.i_resultsrc_e; m_alu = res; m_wd = b;
      m_rd = bus.i_rd_addr_e; m_pc4 = bus.i_pc4_e;
      m_st = bus.i_funct3_e;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic clear_in();
    bus.i_regwrite_e = 0; bus.i_memwrite_e = 0;
    bus.i_branch_e = 0; bus.i_jump_e = 0; bus.i_jalr_e = 0;
    bus.i_resultsrc_e = 0; bus.i_alucontrol_e = 0;
    bus.i_alusrc_e = 0; bus.i_funct3_e = 0;
    bus.i_rd1_e = 0; bus.i_rd2_e = 0; bus.i_imm_e = 0;
    bus.i_pc_e = 0; bus.i_pc4_e = 0; bus.i_rd_addr_e = 0;
    bus.i_forward_a_e = 0; bus.i_forward_b_e = 0;
    bus.i_result_w = 0; bus.i_stall_m = 0; bus.i_flush_m = 0;
  endtask

  task automatic rand_in();
    bus.i_regwrite_e = 1'($urandom); bus.i_memwrite_e = 1'($urandom);
    bus.i_branch_e = 1'($urandom); bus.i_jump_e = ($urandom % 5) == 0;
    bus.i_jalr_e = 1'($urandom); bus.i_resultsrc_e = 2'($urandom);
    bus.i_alucontrol_e = 4'($urandom); bus.i_alusrc_e = 1'($urandom);
    bus.i_funct3_e = 3'($urandom);
    bus.i_rd1_e = ($urandom % 4 == 0) ? 32'd5 : $urandom;
    bus.i_rd2_e = ($urandom % 4 == 0) ? 32'd5 : $urandom;
    bus.i_imm_e = $urandom; bus.i_pc_e = 11'($urandom);
    bus.i_pc4_e = 11'($urandom); bus.i_rd_addr_e = 5'($urandom);
    bus.i_forward_a_e = 2'($urandom);
    bus.i_forward_b_e = 2'($urandom);
    bus.i_result_w = $urandom;
    bus.i_stall_m = ($urandom % 6) == 0;
    bus.i_flush_m = ($urandom % 10) == 0;
  endtask

  task automatic alu_case(string tag, int op, logic [31:0] a,
                          logic [31:0] b, logic [31:0] want);
    clear_in();
    bus.i_alucontrol_e = 4'(op); bus.i_rd1_e = a;
    bus.i_alusrc_e = 1; bus.i_imm_e = b;
    step(tag);
    check({tag, ".const"}, bus.o_alu_result_m, want);
  endtask

  logic [31:0] held;

  initial begin
    clear_in();
    model_zero();
    #1;
    check_regs("reset");
    #20;
    @(negedge clk) rst_n = 1;
    @(posedge clk) #1;

    alu_case("slt", 5, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_case("sltu", 6, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_case("add_wrap", 0, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_case("sra", 9, 32'h8000_0000, 32'd4, 32'hF800_0000);

    alu_case("add34", 0, 32'd3, 32'd4, 32'd7);
    clear_in();
    bus.i_forward_a_e = 2'b10; bus.i_alusrc_e = 1;
    bus.i_imm_e = 1;
    step("fwd_mem");
    check("fwd_mem.const", bus.o_alu_result_m, 32'd8);

    clear_in();
    bus.i_forward_b_e = 2'b01; bus.i_result_w = 32'h55;
    bus.i_memwrite_e = 1; bus.i_rd2_e = 32'h99;
    step("fwd_wb");
    check("fwd_wb.const", bus.o_write_data_m, 32'h55);

    clear_in();
    bus.i_branch_e = 1; bus.i_rd1_e = 5; bus.i_rd2_e = 5;
    bus.i_pc_e = 11'h100; bus.i_imm_e = 32'h20;
    step("beq");
    check("beq.pcsrc_c", 32'(bus.o_pcsrc_e), 32'd1);
    check("beq.tgt_c", 32'(bus.o_pc_target_e), 32'h120);
    bus.i_funct3_e = 3'b001;
    step("bne");
    check("bne.pcsrc_c", 32'(bus.o_pcsrc_e), 32'd0);

    clear_in();
    bus.i_jump_e = 1; bus.i_jalr_e = 1; bus.i_rd1_e = 32'h203;
    step("jalr");
    check("jalr.tgt_c", 32'(bus.o_pc_target_e), 32'h202);

    clear_in();
    bus.i_funct3_e = 3'b010; bus.i_rd2_e = 32'hDEAD_BEEF;
    bus.i_alusrc_e = 1; bus.i_imm_e = 8; bus.i_rd1_e = 32'h10;
    bus.i_memwrite_e = 1; bus.i_regwrite_e = 1;
    step("sw");
    check("sw.alu_c", bus.o_alu_result_m, 32'h18);
    check("sw.wd_c", bus.o_write_data_m, 32'hDEAD_BEEF);
    check("sw.st_c", 32'(bus.o_storetype_m), 32'd2);

    held = bus.o_alu_result_m;
    for (int i = 0; i < 3; i++) begin
      rand_in();
      bus.i_stall_m = 1; bus.i_flush_m = 0;
      step("stall");
    end
    check("stall.held_c", bus.o_alu_result_m, held);
    check("stall.mw_c", 32'(bus.o_memwrite_m), 32'd1);

    rand_in();
    bus.i_stall_m = 1; bus.i_flush_m = 1;
    step("flush_stall");
    check("flush.rw_c", 32'(bus.o_regwrite_m), 32'd0);
    check("flush.mw_c", 32'(bus.o_memwrite_m), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rand_in();
      step("rand");
    end

    rand_in();
    bus.i_stall_m = 1; bus.i_flush_m = 0;
    #2 rst_n = 0;
    #1 model_zero();
    check_regs("midreset");
    check_comb("midreset");
    @(negedge clk) rst_n = 1;
    rand_in();
    bus.i_stall_m = 0; bus.i_flush_m = 0;
    step("post_reset");

    for (int i = 0; i < 200; i++) begin
      rand_in();
      step("rand2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
